// File: rtl/layer_ram_pkg.sv
// rtl/layer_ram_pkg.sv - shared types and widths for the layer RAM loader
package layer_ram_pkg;

  typedef enum logic [1:0] {LD_IDLE, LD_ISSUE, LD_WAIT, LD_GAP} ld_state_t;

  localparam int LAYER_RAM_WORD_W = 16;
  localparam int LAYER_RAM_ADDR_W = 24;

endpackage

// File: rtl/layer_ram_loader_if.sv
// rtl/layer_ram_loader_if.sv - host byte stream, layer RAM write handshake and status
interface layer_ram_loader_if
  import layer_ram_pkg::*;
#(
  parameter int LAYER_ID_W = 8,
  parameter int CNT_W      = LAYER_RAM_ADDR_W
);
  logic                        host_start;
  logic [LAYER_ID_W-1:0]       host_layer_id;
  logic                        host_byte_valid;
  logic [7:0]                  host_byte;
  logic                        host_byte_ready;
  logic                        host_end;
  logic                        ram_rdy;
  logic                        ctrl_write_en;
  logic [LAYER_ID_W-1:0]       ctrl_layerId;
  logic [LAYER_RAM_WORD_W-1:0] ctrl_write_data;
  logic                        pipe_hold;
  logic                        busy;
  logic                        done;
  logic [CNT_W-1:0]            words_written;
  logic                        err_start;

  modport master (
    output host_start, host_layer_id, host_byte_valid, host_byte, host_end, ram_rdy,
    input  host_byte_ready, ctrl_write_en, ctrl_layerId, ctrl_write_data,
    input  pipe_hold, busy, done, words_written, err_start
  );

  modport slave (
    input  host_start, host_layer_id, host_byte_valid, host_byte, host_end, ram_rdy,
    output host_byte_ready, ctrl_write_en, ctrl_layerId, ctrl_write_data,
    output pipe_hold, busy, done, words_written, err_start
  );
endinterface

// File: rtl/layer_ram_word_fifo.sv
// rtl/layer_ram_word_fifo.sv - word FIFO with head and next-head peek
module layer_ram_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk_n,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           head_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + PTR_ONE];
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);

  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Push+pop on a full FIFO rewrites the slot being popped, which is read before the edge.
  always_ff @(posedge clk_n) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/layer_ram_loader.sv
// rtl/layer_ram_loader.sv - packs host bytes into words and drains them into the layer RAM
module layer_ram_loader
  import layer_ram_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LAYER_ID_W = 8,
  parameter int CNT_W      = LAYER_RAM_ADDR_W
) (
  input  logic               clk_n,
  input  logic               rst,
  layer_ram_loader_if.slave  bus
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0]   FIFO_ONE = FCW'(1);
  localparam logic [CNT_W-1:0] WW_ONE   = CNT_W'(1);

  ld_state_t                   state;
  logic                        end_seen;
  logic                        low_valid;
  logic [7:0]                  low_byte;
  logic                        byte_take;
  logic                        flush;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [FCW-1:0]              fifo_count;
  logic [LAYER_RAM_WORD_W-1:0] fifo_din;
  logic [LAYER_RAM_WORD_W-1:0] fifo_head;
  logic [LAYER_RAM_WORD_W-1:0] fifo_head_next;
  logic                        more_after_pop;
  logic                        done_cond;

  // A low byte can always park in the packer; only a high byte needs FIFO room.
  assign bus.host_byte_ready = bus.busy & ~end_seen & (~fifo_full | ~low_valid);
  assign byte_take      = bus.host_byte_valid & bus.host_byte_ready;
  assign flush          = end_seen & low_valid & ~fifo_full;
  assign fifo_push      = (byte_take & low_valid) | flush;
  assign fifo_din       = flush ? {8'h00, low_byte} : {bus.host_byte, low_byte};
  assign fifo_pop       = (state == LD_GAP);
  assign more_after_pop = (fifo_count > FIFO_ONE) | fifo_push;
  assign done_cond      = bus.busy & end_seen & ~low_valid & fifo_empty & (state == LD_IDLE);

  layer_ram_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LAYER_RAM_WORD_W)
  ) u_fifo (
    .clk_n     (clk_n),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) begin
      state               <= LD_IDLE;
      end_seen            <= 1'b0;
      low_valid           <= 1'b0;
      low_byte            <= '0;
      bus.ctrl_write_en   <= 1'b0;
      bus.ctrl_layerId    <= '0;
      bus.ctrl_write_data <= '0;
      bus.pipe_hold       <= 1'b0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.words_written   <= '0;
      bus.err_start       <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      if (bus.host_start) begin
        if (bus.busy) begin
          bus.err_start <= 1'b1;
        end else begin
          bus.ctrl_layerId  <= bus.host_layer_id;
          bus.words_written <= '0;
          bus.err_start     <= 1'b0;
          bus.busy          <= 1'b1;
          bus.pipe_hold     <= 1'b1;
          end_seen          <= 1'b0;
          low_valid         <= 1'b0;
        end
      end

      if (bus.host_end && bus.busy) end_seen <= 1'b1;

      if (byte_take) begin
        low_valid <= ~low_valid;
        if (!low_valid) low_byte <= bus.host_byte;
      end
      if (flush) low_valid <= 1'b0;

      if (done_cond) begin
        bus.done      <= 1'b1;
        bus.busy      <= 1'b0;
        bus.pipe_hold <= 1'b0;
        end_seen      <= 1'b0;
      end

      case (state)
        LD_IDLE: begin
          if (bus.busy && !fifo_empty) begin
            state               <= LD_ISSUE;
            bus.ctrl_write_en   <= 1'b1;
            bus.ctrl_write_data <= fifo_head;
          end
        end
        LD_ISSUE: begin
          if (!bus.ram_rdy) state <= LD_WAIT;
        end
        LD_WAIT: begin
          if (bus.ram_rdy) begin
            state             <= LD_GAP;
            bus.ctrl_write_en <= 1'b0;
          end
        end
        LD_GAP: begin
          if (!(&bus.words_written)) bus.words_written <= bus.words_written + WW_ONE;
          // The next word is either already behind the head or being pushed right now.
          if (more_after_pop) begin
            state               <= LD_ISSUE;
            bus.ctrl_write_en   <= 1'b1;
            bus.ctrl_write_data <= (fifo_count > FIFO_ONE) ? fifo_head_next : fifo_din;
          end else begin
            state <= LD_IDLE;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end
endmodule
